// File: rtl/cmul_pkg.sv
// Shared types for the complex twiddle multiply scheduler.
package cmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } cmul_state_e;

    // Product register indices; also the issue order of the four real products.
    localparam logic [1:0] P_RR = 2'd0;
    localparam logic [1:0] P_II = 2'd1;
    localparam logic [1:0] P_RI = 2'd2;
    localparam logic [1:0] P_IR = 2'd3;

    // Tag travelling alongside each operand pair through the multiplier latency.
    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } cmul_tag_t;

endpackage

// File: rtl/cmul_mul_sched_if.sv
// Operand, multiplier and product-set signals of the twiddle multiply scheduler.
interface cmul_mul_sched_if #(
    parameter int SIZE_DATA = 32
);
    logic                 i_valid;
    logic                 o_ready;
    logic [SIZE_DATA-1:0] i_a_re;
    logic [SIZE_DATA-1:0] i_a_im;
    logic [SIZE_DATA-1:0] i_w_re;
    logic [SIZE_DATA-1:0] i_w_im;
    logic [SIZE_DATA-1:0] o_mul_a;
    logic [SIZE_DATA-1:0] o_mul_b;
    logic [SIZE_DATA-1:0] i_mul_p;
    logic                 o_valid;
    logic                 i_ready;
    logic [SIZE_DATA-1:0] o_p_rr;
    logic [SIZE_DATA-1:0] o_p_ii;
    logic [SIZE_DATA-1:0] o_p_ri;
    logic [SIZE_DATA-1:0] o_p_ir;

    // The scheduler itself.
    modport slave (
        input  i_valid, i_a_re, i_a_im, i_w_re, i_w_im, i_mul_p, i_ready,
        output o_ready, o_mul_a, o_mul_b, o_valid, o_p_rr, o_p_ii, o_p_ri, o_p_ir
    );

    // The surrounding datapath (upstream source, multiplier, add/sub stage).
    modport master (
        output i_valid, i_a_re, i_a_im, i_w_re, i_w_im, i_mul_p, i_ready,
        input  o_ready, o_mul_a, o_mul_b, o_valid, o_p_rr, o_p_ii, o_p_ri, o_p_ir
    );
endinterface

// File: rtl/cmul_tag_pipe.sv
// DEPTH-deep shift register of product tags, matched to the multiplier latency.
module cmul_tag_pipe
    import cmul_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      clr,
    input  cmul_tag_t tag_in,
    output cmul_tag_t tag_out,
    output logic      pend
);
    cmul_tag_t stage [DEPTH];

    // Shift tags one stage per cycle; clear drops every tag in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[DEPTH-1];

    // Tags still in flight behind the exit stage; the exit stage retires this cycle.
    always_comb begin
        pend = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) pend = pend | stage[i].vld;
    end
endmodule

// File: rtl/cmul_mul_sched.sv
// Issues the four real products of a*w onto one shared FP32 multiplier and
// gathers the returning products into a single output set.
module cmul_mul_sched
    import cmul_pkg::*;
#(
    parameter int SIZE_DATA = 32,
    parameter int MUL_LAT   = 2
) (
    input logic             i_clk,
    input logic             i_rst,
    cmul_mul_sched_if.slave bus
);
    cmul_state_e          state, state_nxt;
    logic [1:0]           k, k_nxt;
    logic [SIZE_DATA-1:0] lat_a_re, lat_a_im, lat_w_re, lat_w_im;
    logic [SIZE_DATA-1:0] mul_a, mul_b, nxt_a, nxt_b;
    logic [SIZE_DATA-1:0] prod [4];
    logic [3:0]           done, wr_mask;
    logic                 accept, pend;
    cmul_tag_t            tag_in, tag_out;

    assign accept  = (state == IDLE) && bus.i_valid;
    assign k_nxt   = k + 2'd1;
    assign wr_mask = tag_out.vld ? (4'b0001 << tag_out.idx) : 4'b0000;

    // Tag describes the pair currently on the multiplier inputs.
    assign tag_in.vld = (state == ISSUE);
    assign tag_in.idx = k;

    cmul_tag_pipe #(.DEPTH(MUL_LAT)) u_tag_pipe (
        .clk    (i_clk),
        .clr    (i_rst),
        .tag_in (tag_in),
        .tag_out(tag_out),
        .pend   (pend)
    );

    // Next-state decode; the DRAIN exit counts the product landing this cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_valid) state_nxt = ISSUE;
            ISSUE:   if (k == 2'd3) state_nxt = DRAIN;
            DRAIN:   if (!pend && ((done | wr_mask) == 4'hF)) state_nxt = OUT;
            OUT:     if (bus.i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand pair for the next cycle: pair 0 comes straight from the inputs on
    // the accept edge, later pairs from the latched copies; zero otherwise.
    always_comb begin
        nxt_a = '0;
        nxt_b = '0;
        if (accept) begin
            nxt_a = bus.i_a_re;
            nxt_b = bus.i_w_re;
        end else if (state == ISSUE) begin
            case (k_nxt)
                P_II:    begin nxt_a = lat_a_im; nxt_b = lat_w_im; end
                P_RI:    begin nxt_a = lat_a_re; nxt_b = lat_w_im; end
                P_IR:    begin nxt_a = lat_a_im; nxt_b = lat_w_re; end
                default: begin nxt_a = '0;       nxt_b = '0;       end
            endcase
        end
    end

    // State, issue counter and registered multiplier operands.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            k     <= 2'd0;
            mul_a <= '0;
            mul_b <= '0;
        end else begin
            state <= state_nxt;
            k     <= (state == ISSUE) ? k_nxt : 2'd0;
            mul_a <= nxt_a;
            mul_b <= nxt_b;
        end
    end

    // Operand latch on accept; written-product mask restarts with each set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lat_a_re <= '0;
            lat_a_im <= '0;
            lat_w_re <= '0;
            lat_w_im <= '0;
            done     <= 4'h0;
        end else if (accept) begin
            lat_a_re <= bus.i_a_re;
            lat_a_im <= bus.i_a_im;
            lat_w_re <= bus.i_w_re;
            lat_w_im <= bus.i_w_im;
            done     <= 4'h0;
        end else begin
            done     <= done | wr_mask;
        end
    end

    // Products land only from the tag pipe and are kept after the handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) prod[i] <= '0;
        end else if (tag_out.vld) begin
            prod[tag_out.idx] <= bus.i_mul_p;
        end
    end

    assign bus.o_ready = (state == IDLE);
    assign bus.o_valid = (state == OUT);
    assign bus.o_mul_a = mul_a;
    assign bus.o_mul_b = mul_b;
    assign bus.o_p_rr  = prod[P_RR];
    assign bus.o_p_ii  = prod[P_II];
    assign bus.o_p_ri  = prod[P_RI];
    assign bus.o_p_ir  = prod[P_IR];
endmodule
